// File: rtl/ram_bank_ctrl.sv
// Single-port word RAM with a valid/ready request port, byte strobes, base-address
// translation with range/alignment errors, in-order pipelined responses and a zero-fill after reset.
module ram_bank_ctrl #(
  parameter int unsigned        DATA_W       = 32,
  parameter int unsigned        ADDR_W       = 32,
  parameter int unsigned        DEPTH_LOG2   = 14,
  parameter logic [ADDR_W-1:0]  BASE_ADDR    = '0,
  parameter int unsigned        READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic                resp_we,
  output logic                resp_err,
  output logic [DATA_W-1:0]   resp_rdata
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned B      = $clog2(NB);
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned SPAN_W = DEPTH_LOG2 + B;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   init_idx_q, init_idx_d;

  logic [ADDR_W-1:0]       offset;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    range_err, align_err, req_err, accept;

  assign offset    = req_addr - BASE_ADDR;
  assign req_idx   = offset[SPAN_W-1:B];
  assign align_err = |offset[B-1:0];
  assign req_err   = range_err | align_err;

  // Addresses below BASE_ADDR wrap to a huge offset and land here as range errors.
  generate
    if (SPAN_W < ADDR_W) begin : g_range
      assign range_err = |offset[ADDR_W-1:SPAN_W];
    end else begin : g_norange
      assign range_err = 1'b0;
    end
  endgenerate

  assign req_ready = (state_q == ST_RUN);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == ST_INIT) begin
      init_idx_d = init_idx_q + DEPTH_LOG2'(1);
      if (init_idx_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  // Single write port shared between the zero-fill and accepted writes.
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DATA_W-1:0]     wr_data;
  logic [NB-1:0]         wr_be;

  assign wr_idx  = (state_q == ST_INIT) ? init_idx_q : req_idx;
  assign wr_data = (state_q == ST_INIT) ? '0 : req_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign wr_be[gi] = (state_q == ST_INIT) |
                         (accept & req_we & ~req_err & req_wstrb[gi]);
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (wr_be[k]) begin
        mem[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
      end
    end
    rd_data_q <= mem[req_idx];
  end

  // Response control pipeline; stage 0 pairs with the RAM output register.
  logic [READ_LATENCY-1:0] vld_q, vld_d, we_q, we_d, err_q, err_d;
  logic [DATA_W-1:0]       head_data;

  always_comb begin
    vld_d    = '0;
    we_d     = '0;
    err_d    = '0;
    vld_d[0] = accept;
    we_d[0]  = accept & req_we;
    err_d[0] = accept & req_err;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      we_d[i]  = we_q[i-1];
      err_d[i] = err_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      vld_q      <= '0;
      we_q       <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      vld_q      <= vld_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  assign head_data = (vld_q[0] & ~we_q[0] & ~err_q[0]) ? rd_data_q : '0;

  generate
    if (READ_LATENCY > 1) begin : g_dpipe
      logic [DATA_W-1:0] dat_q [READ_LATENCY-1];
      logic [DATA_W-1:0] dat_d [READ_LATENCY-1];

      always_comb begin
        dat_d[0] = head_data;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          dat_d[i] = dat_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < READ_LATENCY - 1; i++) begin
            dat_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < READ_LATENCY - 1; i++) begin
            dat_q[i] <= dat_d[i];
          end
        end
      end

      assign resp_rdata = dat_q[READ_LATENCY-2];
    end else begin : g_dnopipe
      assign resp_rdata = head_data;
    end
  endgenerate

  assign resp_valid = vld_q[READ_LATENCY-1];
  assign resp_we    = we_q[READ_LATENCY-1];
  assign resp_err   = err_q[READ_LATENCY-1];

endmodule

// File: tb/tb_ram_bank_ctrl.sv
// Directed bench for ram_bank_ctrl (16 words, base bfc00000, latency 3) with a response scoreboard.
module tb_ram_bank_ctrl;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          DL2  = 4;
  localparam int          RL   = 3;
  localparam logic [31:0] BASE = 32'hbfc00000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [3:0]    req_wstrb;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_we;
  logic          resp_err;
  logic [31:0]   resp_rdata;

  ram_bank_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL2), .BASE_ADDR(BASE), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_err(resp_err),
    .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Scoreboard side: every response must match the oldest outstanding request.
  always @(negedge clk) begin
    if (resetn) begin
      if (resp_valid) begin
        tests++;
        assert (exp_q.size() != 0)
          else begin
            fails++;
            $error("FAIL unexpected_resp: observed we=%0b err=%0b rdata=%h expected no response",
                   resp_we, resp_err, resp_rdata);
          end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("resp_fields", {resp_we, resp_err, resp_rdata}, {mon_e.we, mon_e.err, mon_e.data});
          chk("resp_latency", 64'(cyc - mon_e.acc), 64'(RL - 1));
          $display("[TB] resp we=%0b err=%0b rdata=%h (expected we=%0b err=%0b rdata=%h)",
                   resp_we, resp_err, resp_rdata, mon_e.we, mon_e.err, mon_e.data);
        end
      end else begin
        chk("idle_outputs", {resp_we, resp_err, resp_rdata}, 64'd0);
      end
    end
  end

  task automatic issue(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_data);
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_wstrb = strb;
    req_addr  = addr;
    req_wdata = wdata;
    chk("req_ready_run", req_ready, 1);
    @(posedge clk);
    #1;
    e.we   = we;
    e.err  = exp_err;
    e.data = exp_data;
    e.acc  = cyc;
    exp_q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic rd_word(input int w);
    issue(1'b0, 4'h0, BASE + 32'(w * 4), 32'h0, 1'b0, ref_mem[w]);
  endtask

  task automatic wr_word(input int w, input logic [31:0] data, input logic [3:0] strb);
    issue(1'b1, strb, BASE + 32'(w * 4), data, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) ref_mem[w][k*8 +: 8] = data[k*8 +: 8];
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
  endtask

  // Starts at the negedge where resetn was released; counts cycles with req_ready low.
  task automatic count_fill(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) break;
      n++;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_valid"}, resp_valid, 0);
    chk({tag, "_we"}, resp_we, 0);
    chk({tag, "_err"}, resp_err, 0);
    chk({tag, "_rdata"}, resp_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wstrb = 4'h0;
    req_addr  = BASE;
    req_wdata = 32'h0;
    clear_ref();

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Fill with a request held pending the whole time.
    req_valid = 1'b1;
    resetn    = 1'b1;
    count_fill(n);
    chk("fill_len", n, 16);
    $display("[TB] fill ready-low cycles=%0d", n);

    for (int w = 0; w < 16; w++) rd_word(w);

    // Byte strobes.
    wr_word(3, 32'hAABBCCDD, 4'hF);
    wr_word(3, 32'h11223344, 4'b0101);
    issue(1'b0, 4'h0, BASE + 32'd12, 32'h0, 1'b0, 32'hAA22CC44);

    // Base translation and error cases.
    wr_word(1, 32'hCAFEF00D, 4'hF);
    issue(1'b0, 4'h0, 32'hbfc00004, 32'h0, 1'b0, 32'hCAFEF00D);
    issue(1'b0, 4'h0, 32'hbfc00040, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 4'h0, 32'hbfc00002, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 4'hF, 32'hbfbffffc, 32'hDEADBEEF, 1'b1, 32'h0);
    issue(1'b1, 4'hF, 32'hbfc00042, 32'hDEADBEEF, 1'b1, 32'h0);
    for (int w = 0; w < 16; w++) rd_word(w);

    // Back-to-back write then reads of the same word.
    wr_word(6, 32'h5A5AA5A5, 4'hF);
    rd_word(6);
    rd_word(6);
    rd_word(6);

    // Zero-strobe write.
    wr_word(5, 32'h12345678, 4'hF);
    wr_word(5, 32'hFFFFFFFF, 4'h0);
    rd_word(5);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_1", exp_q.size(), 0);

    // Reset with two reads in flight.
    rd_word(5);
    rd_word(6);
    resetn = 1'b0;
    exp_q.delete();
    clear_ref();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("inflight_drop", resp_valid, 0);
    end
    check_reset_outputs("rst2");

    // Restart fill, then reset again at init_idx = 7.
    req_valid = 1'b1;
    resetn    = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_fill_ready", req_ready, 0);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst3");
    resetn = 1'b1;
    count_fill(n);
    chk("refill_len", n, 16);
    $display("[TB] refill ready-low cycles=%0d", n);

    rd_word(3);
    rd_word(5);
    rd_word(6);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_2", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
